// File: rtl/div_signed_stage_if.sv
// Handshake and divider-side bus of div_signed_stage: operand input, result output,
// and the magnitude/quotient link to the external combinational unsigned divider.
// master drives operands, out_ready and div_q; slave is the divider stage itself.
interface div_signed_stage_if #(
  parameter int N = 8,
  parameter int M = N
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [M-1:0] b;
  logic [N-1:0] div_a;
  logic [M-1:0] div_b;
  logic [N-1:0] div_q;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] q;
  logic         dbz;

  modport master (
    output in_valid, a, b, div_q, out_ready,
    input  in_ready, div_a, div_b, out_valid, q, dbz
  );

  modport slave (
    input  in_valid, a, b, div_q, out_ready,
    output in_ready, div_a, div_b, out_valid, q, dbz
  );
endinterface

// File: rtl/div_signed_stage.sv
// Purpose: two-stage wrapper around an external unsigned array divider; optional signed mode via DIV_SIGNED_EN.
// Latency: 2 cycles from input transfer to out_valid, one result per cycle when unstalled.
// Backpressure: result held stable while out_valid && !out_ready; S1 refills in the cycle it drains.
module div_signed_stage #(
  parameter int N = 8,
  parameter int M = N
) (
  input logic            clk,
  input logic            rst,
  div_signed_stage_if.slave bus
);

  // S1: operand magnitudes plus flags, feeding the divider
  logic         s1_valid;
  logic [N-1:0] s1_a;
  logic [M-1:0] s1_b;
  logic         s1_neg;
  logic         s1_dbz;

  // S2: final result
  logic         out_valid;
  logic [N-1:0] q_r;
  logic         dbz_r;

  // Magnitudes and sign of the incoming operand pair
  logic [N-1:0] a_mag;
  logic [M-1:0] b_mag;
  logic         neg_in;
  logic         dbz_in;

  logic s2_load;
  logic in_ready;

`ifdef DIV_SIGNED_EN
  // Two's complement magnitudes; the most-negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  assign a_mag  = bus.a[N-1] ? ({N{1'b0}} - bus.a) : bus.a;
  assign b_mag  = bus.b[M-1] ? ({M{1'b0}} - bus.b) : bus.b;
  assign neg_in = bus.a[N-1] ^ bus.b[M-1];
`else
  assign a_mag  = bus.a;
  assign b_mag  = bus.b;
  assign neg_in = 1'b0;
`endif

  assign dbz_in = (bus.b == {M{1'b0}});

  // S2 takes S1 whenever the output slot is empty or being consumed now
  assign s2_load  = s1_valid && (!out_valid || bus.out_ready);
  assign in_ready = !s1_valid || s2_load;

  assign bus.in_ready  = in_ready;
  assign bus.div_a     = s1_a;
  assign bus.div_b     = s1_b;
  assign bus.out_valid = out_valid;
  assign bus.q         = q_r;
  assign bus.dbz       = dbz_r;

  // S1 capture: accept a new pair whenever the stage is free or draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_neg   <= 1'b0;
      s1_dbz   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a   <= a_mag;
        s1_b   <= b_mag;
        s1_neg <= neg_in;
        s1_dbz <= dbz_in;
      end
    end
  end

  // S2 result: force all-ones on divide-by-zero, otherwise apply the sign to div_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      q_r       <= '0;
      dbz_r     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      if (s1_dbz) begin
        q_r   <= {N{1'b1}};
        dbz_r <= 1'b1;
      end else begin
        q_r   <= s1_neg ? ({N{1'b0}} - bus.div_q) : bus.div_q;
        dbz_r <= 1'b0;
      end
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_signed_stage.sv
// Self-checking bench for div_signed_stage with N = M = 8 and a behavioural
// unsigned divider attached; expected results come from plain integer division.
module tb_div_signed_stage;

  logic clk;
  logic rst;

  div_signed_stage_if #(.N(8), .M(8)) bus ();

  div_signed_stage #(.N(8), .M(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // External combinational unsigned divider
  assign bus.div_q = (bus.div_b == 8'd0) ? 8'hFF : 8'(bus.div_a / bus.div_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  bit last_in_fire;
  bit last_out_fire;

  // Reference result {q, dbz} from the arithmetic meaning of the operands
  function automatic logic [8:0] ref_div(input logic [7:0] x, input logic [7:0] y);
    int sx, sy, r;
    logic [31:0] rv;
    if (y == 8'd0) return {8'hFF, 1'b1};
`ifdef DIV_SIGNED_EN
    sx = int'($signed(x));
    sy = int'($signed(y));
`else
    sx = int'(x);
    sy = int'(y);
`endif
    r  = sx / sy;
    rv = r;
    return {rv[7:0], 1'b0};
  endfunction

  // Magnitude the divider should see for an operand
  function automatic logic [7:0] ref_mag(input logic [7:0] x);
    int sx;
    logic [31:0] rv;
`ifdef DIV_SIGNED_EN
    sx = int'($signed(x));
    if (sx < 0) sx = -sx;
`else
    sx = int'(x);
`endif
    rv = sx;
    return rv[7:0];
  endfunction

  // Advance one clock, logging transfers decided by the pre-edge values
  task automatic tick();
    #1;
    last_in_fire  = bus.in_valid && bus.in_ready;
    last_out_fire = bus.out_valid && bus.out_ready;
    if (last_in_fire)  exp_q.push_back(ref_div(bus.a, bus.b));
    if (last_out_fire) obs_q.push_back({bus.q, bus.dbz});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 8'd0;
    bus.b         = 8'd0;
    bus.out_ready = 1'b0;
    #2;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", bus.q); end
    checks++; if (bus.dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", bus.dbz); end
    checks++; if (bus.div_a !== 8'h00 || bus.div_b !== 8'h00) begin errors++; $display("FAIL reset_div_ops got %h/%h want 00/00", bus.div_a, bus.div_b); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] ta [5] = '{8'd200, 8'h9C, 8'h80, 8'd55, 8'd9};
    logic [7:0] tb_ [5] = '{8'd7,  8'd7,  8'hFF, 8'd0,  8'd3};
    logic [8:0] e;
    for (int i = 0; i < 5; i++) begin
      e = ref_div(ta[i], tb_[i]);
      bus.a = ta[i];
      bus.b = tb_[i];
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.div_a !== ref_mag(ta[i]) || bus.div_b !== ref_mag(tb_[i])) begin
        errors++; $display("FAIL dir%0d_div_ops got %h/%h want %h/%h", i, bus.div_a, bus.div_b, ref_mag(ta[i]), ref_mag(tb_[i]));
      end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b want 0", i, bus.out_valid); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.q !== e[8:1] || bus.dbz !== e[0]) begin
        errors++; $display("FAIL dir%0d_result got v=%b q=%h dbz=%b want v=1 q=%h dbz=%b", i, bus.out_valid, bus.q, bus.dbz, e[8:1], e[0]);
      end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_consumed got %b want 0", i, bus.out_valid); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random_stream();
    bit hold;
    bit watch;
    logic [7:0] sq;
    logic sd;
    int n;
    exp_q.delete();
    obs_q.delete();
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 9))
          0:       begin bus.a = 8'($urandom); bus.b = 8'd0; end
          1:       begin bus.a = 8'h80; bus.b = 8'hFF; end
          default: begin bus.a = 8'($urandom); bus.b = 8'($urandom); end
        endcase
      end
      bus.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      watch = bus.out_valid && !bus.out_ready;
      sq = bus.q;
      sd = bus.dbz;
      tick();
      hold = bus.in_valid && !last_in_fire;
      if (watch) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.q !== sq || bus.dbz !== sd) begin
          errors++; $display("FAIL rnd_stall_stable cycle %0d got v=%b q=%h dbz=%b want v=1 q=%h dbz=%b", c, bus.out_valid, bus.q, bus.dbz, sq, sd);
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rnd_result %0d got q=%h dbz=%b want q=%h dbz=%b", i, obs_q[i][8:1], obs_q[i][0], exp_q[i][8:1], exp_q[i][0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] oa [6];
    logic [7:0] ob [6];
    int idx;
    int n;
    logic [7:0] sq;
    logic sd;
    for (int i = 0; i < 6; i++) begin
      oa[i] = 8'($urandom);
      ob[i] = 8'($urandom_range(1, 255));
    end
    exp_q.delete();
    obs_q.delete();
    idx = 0;
    bus.out_ready = 1'b0;
    sq = 8'h00;
    sd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.a = oa[idx];
      bus.b = ob[idx];
      tick();
      if (last_in_fire) idx++;
      if (c == 2) begin sq = bus.q; sd = bus.dbz; end
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepts got %0d want 2", idx); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.q !== sq || bus.dbz !== sd) begin
      errors++; $display("FAIL bp_hold got v=%b q=%h dbz=%b want v=1 q=%h dbz=%b", bus.out_valid, bus.q, bus.dbz, sq, sd);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.a = oa[idx];
      bus.b = ob[idx];
      tick();
      if (last_in_fire) idx++;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    checks++; if (obs_q.size() != 6 || exp_q.size() != 6) begin errors++; $display("FAIL bp_count got %0d want 6 (accepted %0d)", obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_result %0d got q=%h dbz=%b want q=%h dbz=%b", i, obs_q[i][8:1], obs_q[i][0], exp_q[i][8:1], exp_q[i][0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_in_flight();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 8'd100;
    bus.b = 8'd5;
    tick();
    bus.a = 8'd77;
    bus.b = 8'd0;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rif_full got v=%b rdy=%b want v=1 rdy=0", bus.out_valid, bus.in_ready);
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rif_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rif_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.q !== 8'h00 || bus.dbz !== 1'b0) begin errors++; $display("FAIL rif_clear got q=%h dbz=%b want q=00 dbz=0", bus.q, bus.dbz); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.delete();
    obs_q.delete();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rif_stale cycle %0d got %b want 0", c, bus.out_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random_stream();
    test_backpressure();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_signed_stage.md
DIV_SIGNED_STAGE -- requirements
Module: div_signed_stage

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the dividend and quotient width in bits.
REQ-002 The block SHALL have parameter M, default N, giving the divisor width in bits.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; every register updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, and is the reset: asynchronous and active-high.
REQ-005 Port in_valid SHALL be an input, 1 bit wide, and indicates the upstream operand pair is valid.
REQ-006 Port in_ready SHALL be an output, 1 bit wide, and indicates the block accepts an operand pair this cycle.
REQ-007 Port a SHALL be an input, N bits wide, and is the dividend.
REQ-008 Port b SHALL be an input, M bits wide, and is the divisor.
REQ-009 Port div_a SHALL be an output, N bits wide, and is the dividend magnitude driven to the external combinational unsigned array divider.
REQ-010 Port div_b SHALL be an output, M bits wide, and is the divisor magnitude driven to the same divider.
REQ-011 Port div_q SHALL be an input, N bits wide, and is the unsigned quotient returned combinationally by the divider.
REQ-012 Port out_valid SHALL be an output, 1 bit wide, and indicates a result is valid.
REQ-013 Port out_ready SHALL be an input, 1 bit wide, and indicates downstream accepts the result.
REQ-014 Port q SHALL be an output, N bits wide, and is the final quotient.
REQ-015 Port dbz SHALL be an output, 1 bit wide, and flags a divide-by-zero on the result currently presented.

Function
REQ-016 Two register stages SHALL exist: S1 holds operand magnitudes, negate flag and dbz flag; S2 holds q and dbz.
REQ-017 div_a and div_b SHALL be driven only from S1 registers, never combinationally from a or b.
REQ-018 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-019 S2 SHALL load when S1 is valid and (!out_valid || out_ready).
REQ-020 in_ready SHALL equal !s1_valid || S2-load condition, so that S1 refills in the same cycle it drains.
REQ-021 With no backpressure, latency SHALL be 2 cycles from input transfer to out_valid, at throughput one result per cycle.
REQ-022 Under backpressure, q and dbz SHALL remain stable while out_valid && !out_ready.
REQ-023 No transfer SHALL be lost or duplicated; ordering SHALL be preserved.
REQ-024 b == 0 SHALL set the S1 dbz flag; at S2, q SHALL be forced to all ones and dbz = 1, ignoring div_q.
REQ-025 When b != 0, S2 SHALL compute q as div_q, negated in two's complement if the negate flag is set, truncated to N bits.
REQ-026 A simultaneous input transfer and output transfer SHALL both complete in the same cycle.
REQ-027 Asserting in_valid while in_ready = 0 SHALL have no effect; upstream holds its operands.

Reset
REQ-028 On rst, s1_valid, out_valid, q, dbz and all S1 data registers SHALL clear to 0 immediately, independent of clk.
REQ-029 While rst is high, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-030 An operation in flight when rst asserts SHALL be discarded, and no result for it SHALL be presented after reset.

Configuration
REQ-031 Macro DIV_SIGNED_EN defined: a and b SHALL be two's complement; S1 SHALL store |a| in N bits and |b| in M bits, with negate = a[N-1] ^ b[M-1].
REQ-032 In signed mode, the most-negative dividend / -1 SHALL yield q = the most-negative value (wrap), with dbz = 0.
REQ-033 Macro DIV_SIGNED_EN undefined: operands SHALL pass unchanged to S1, negate SHALL be tied to 0, and no sign logic SHALL be synthesised.

Verification (N = M = 8, external 8x8 unsigned divider attached)
REQ-034 Unsigned build, a=200, b=7, out_ready=1 -> div_a=200, div_b=7 one cycle later; q=28, dbz=0, out_valid two cycles after the transfer.
REQ-035 Signed build, a=-100 (0x9C), b=7 -> div_a=100; q=-14 (0xF2); a=-128, b=-1 -> q=0x80, dbz=0.
REQ-036 a=55, b=0 -> q=0xFF, dbz=1; the next operation, a=9, b=3, returns q=3, dbz=0.
REQ-037 Stream of 6 operations with out_ready held low for 4 cycles -> in_ready drops after 2 accepts; q holds stable; all 6 results arrive in order, none lost.
REQ-038 rst pulse between clock edges with both stages full -> out_valid=0 and in_ready=1 immediately; no stale result appears after rst deasserts.
